// File: rtl/cmu_pkg.sv
// Shared control-memory definitions for the buffer allocator and the chain reader.
// A control entry is 11 bits: bit 0 = allocated, bits [10:1] = next block address.
// Address 0 is the null pointer and terminates a chain.
package cmu_pkg;

    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned CTRL_W     = 11;
    localparam int unsigned CNT_W      = 6;
    // Longest legal chain; matches the 6-bit packet length field.
    localparam int unsigned MAX_BLOCKS = 63;

    typedef logic [ADDR_W-1:0] block_addr_t;
    typedef logic [CNT_W-1:0]  blk_cnt_t;

    typedef struct packed {
        block_addr_t next;
        logic        alloc;
    } ctrl_entry_t;

endpackage

// File: rtl/chain_reader_if.sv
// Bundle of the chain reader's handshake and memory-side signals.
//   start_valid/start_ready/head_addr : packet dequeue request
//   ctrl_raddr/ctrl_rdata             : control-memory read port (1-cycle latency)
//   blk_valid/blk_ready/blk_addr/blk_last : block address stream to the datapath
//   free_en/free_addr                 : free requests to the allocator
//   done/err/blk_count                : status
// Modport master is the reader's view; slave is the environment's view.
interface chain_reader_if;
    import cmu_pkg::*;

    logic              start_valid;
    logic              start_ready;
    block_addr_t       head_addr;
    block_addr_t       ctrl_raddr;
    logic [CTRL_W-1:0] ctrl_rdata;
    logic              blk_valid;
    logic              blk_ready;
    block_addr_t       blk_addr;
    logic              blk_last;
    logic              free_en;
    block_addr_t       free_addr;
    logic              done;
    logic              err;
    blk_cnt_t          blk_count;

    modport master (
        input  start_valid, head_addr, ctrl_rdata, blk_ready,
        output start_ready, ctrl_raddr, blk_valid, blk_addr, blk_last,
               free_en, free_addr, done, err, blk_count
    );

    modport slave (
        output start_valid, head_addr, ctrl_rdata, blk_ready,
        input  start_ready, ctrl_raddr, blk_valid, blk_addr, blk_last,
               free_en, free_addr, done, err, blk_count
    );

endinterface

// File: rtl/chain_reader.sv
// Packet dequeue engine: walks a packet's linked list in control memory, emits one
// data block address per segment, and frees each block after it is consumed.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : synchronous, active-high
//   bus   : chain_reader_if.master (request, control read, block stream, free, status)
module chain_reader
    import cmu_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    chain_reader_if.master bus
);

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StEmit, StDone} rd_state_t;

    localparam blk_cnt_t MaxCnt = blk_cnt_t'(MAX_BLOCKS);

    rd_state_t   state_q, state_d;
    block_addr_t cur_q, cur_d;
    block_addr_t nxt_q, nxt_d;
    blk_cnt_t    cnt_q, cnt_d;
    block_addr_t raddr_q, raddr_d;
    logic        free_en_q, free_en_d;
    block_addr_t free_addr_q, free_addr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    ctrl_entry_t entry;
    blk_cnt_t    cnt_inc;

    assign entry   = ctrl_entry_t'(bus.ctrl_rdata);
    assign cnt_inc = (cnt_q == MaxCnt) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        cnt_d       = cnt_q;
        raddr_d     = '0;
        free_en_d   = 1'b0;
        free_addr_d = '0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start_valid) begin
                    if (bus.head_addr != '0) begin
                        cur_d   = bus.head_addr;
                        cnt_d   = '0;
                        raddr_d = bus.head_addr;
                        state_d = StFetch;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StFetch: begin
                state_d = StWait;
            end
            StWait: begin
                // An unallocated entry means the chain is corrupt: abort, free nothing more.
                if (!entry.alloc) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    nxt_d   = entry.next;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (bus.blk_ready) begin
                    cnt_d       = cnt_inc;
                    free_en_d   = 1'b1;
                    free_addr_d = cur_q;
                    cur_d       = nxt_q;
                    if (nxt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else if (cnt_inc == MaxCnt) begin
                        // Loop guard: nxt_q stays non-null so DONE raises err instead.
                        state_d = StDone;
                    end else begin
                        // Next fetch overlaps the free of the block just consumed.
                        raddr_d = nxt_q;
                        state_d = StFetch;
                    end
                end
            end
            StDone: begin
                err_d   = (nxt_q != '0);
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            nxt_q       <= '0;
            cnt_q       <= '0;
            raddr_q     <= '0;
            free_en_q   <= 1'b0;
            free_addr_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            cnt_q       <= cnt_d;
            raddr_q     <= raddr_d;
            free_en_q   <= free_en_d;
            free_addr_q <= free_addr_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Block stream is decoded from state so it stays stable while stalled.
    assign bus.start_ready = (state_q == StIdle);
    assign bus.blk_valid   = (state_q == StEmit);
    assign bus.blk_addr    = (state_q == StEmit) ? cur_q : '0;
    assign bus.blk_last    = (state_q == StEmit) && (nxt_q == '0);
    assign bus.ctrl_raddr  = raddr_q;
    assign bus.free_en     = free_en_q;
    assign bus.free_addr   = free_addr_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.blk_count   = cnt_q;

endmodule

// File: tb/tb_chain_reader.sv
// Scoreboard bench for chain_reader: stimulus pushes expected block, free, done and
// err events (with the cycle they must occur in); a negedge monitor pops and compares.
module tb_chain_reader;
    import cmu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    chain_reader_if bus();

    chain_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Control memory model, synchronous read.
    logic [CTRL_W-1:0] mem [0:1023];
    always @(posedge clk) bus.ctrl_rdata <= mem[bus.ctrl_raddr];

    typedef struct {int addr; int last; int cyc;} blk_exp_t;
    typedef struct {int addr; int cyc;} free_exp_t;

    blk_exp_t  exp_blk[$];
    free_exp_t exp_free[$];
    int        exp_done[$];
    int        exp_err[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic [CTRL_W-1:0] enc(input int nxt, input bit alloc);
        return {nxt[9:0], alloc};
    endfunction

    // Monitor
    always @(negedge clk) begin
        blk_exp_t  eb;
        free_exp_t ef;
        int        ec;
        if (!reset) begin
            if (bus.blk_valid && bus.blk_ready) begin
                check("blk_expected", (exp_blk.size() > 0) ? 1 : 0, 1);
                if (exp_blk.size() > 0) begin
                    eb = exp_blk.pop_front();
                    check("blk_addr", bus.blk_addr, eb.addr);
                    check("blk_last", bus.blk_last, eb.last);
                    check("blk_cyc", cyc, eb.cyc);
                end
            end
            if (bus.free_en) begin
                check("free_expected", (exp_free.size() > 0) ? 1 : 0, 1);
                if (exp_free.size() > 0) begin
                    ef = exp_free.pop_front();
                    check("free_addr", bus.free_addr, ef.addr);
                    check("free_cyc", cyc, ef.cyc);
                end
            end
            if (bus.done) begin
                check("done_expected", (exp_done.size() > 0) ? 1 : 0, 1);
                if (exp_done.size() > 0) begin
                    ec = exp_done.pop_front();
                    check("done_cyc", cyc, ec);
                end
            end
            if (bus.err) begin
                check("err_expected", (exp_err.size() > 0) ? 1 : 0, 1);
                if (exp_err.size() > 0) begin
                    ec = exp_err.pop_front();
                    check("err_cyc", cyc, ec);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pkt(input int head, output int c0);
        tick();
        bus.start_valid = 1'b1;
        bus.head_addr   = block_addr_t'(head);
        c0 = cyc;
        tick();
        bus.start_valid = 1'b0;
        bus.head_addr   = '0;
    endtask

    task automatic push_blk(input int a, input int l, input int c);
        exp_blk.push_back('{a, l, c});
    endtask

    task automatic push_free(input int a, input int c);
        exp_free.push_back('{a, c});
    endtask

    // Bounded wait for the end-of-packet pulse (done or err).
    task automatic wait_end(input string name);
        int found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (bus.done || bus.err) found = 1;
        end
        check({name, "_end_seen"}, found, 1);
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_start_ready"}, bus.start_ready, 1);
        check({p, "_blk_valid"},   bus.blk_valid,   0);
        check({p, "_blk_addr"},    bus.blk_addr,    0);
        check({p, "_blk_last"},    bus.blk_last,    0);
        check({p, "_ctrl_raddr"},  bus.ctrl_raddr,  0);
        check({p, "_free_en"},     bus.free_en,     0);
        check({p, "_free_addr"},   bus.free_addr,   0);
        check({p, "_done"},        bus.done,        0);
        check({p, "_err"},         bus.err,         0);
        check({p, "_blk_count"},   bus.blk_count,   0);
    endtask

    initial begin
        int c0;
        bus.start_valid = 1'b0;
        bus.head_addr   = '0;
        bus.blk_ready   = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[5] = enc(9, 1'b1);
        mem[9] = enc(2, 1'b1);
        mem[2] = enc(0, 1'b1);
        mem[7] = enc(0, 1'b1);
        mem[3] = enc(4, 1'b1);
        mem[4] = enc(8, 1'b0);
        mem[6] = enc(6, 1'b1);

        repeat (3) tick();
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Chain 5 -> 9 -> 2, ready high.
        start_pkt(5, c0);
        push_blk(5, 0, c0 + 3); push_blk(9, 0, c0 + 6); push_blk(2, 1, c0 + 9);
        push_free(5, c0 + 4); push_free(9, c0 + 7); push_free(2, c0 + 10);
        exp_done.push_back(c0 + 10);
        @(negedge clk);
        check("t1_ctrl_raddr", bus.ctrl_raddr, 5);
        wait_end("t1");
        check("t1_blk_count", bus.blk_count, 3);
        repeat (2) tick();

        // Same chain, block 9 stalled 4 cycles.
        start_pkt(5, c0);
        push_blk(5, 0, c0 + 3); push_blk(9, 0, c0 + 10); push_blk(2, 1, c0 + 13);
        push_free(5, c0 + 4); push_free(9, c0 + 11); push_free(2, c0 + 14);
        exp_done.push_back(c0 + 14);
        repeat (5) tick();
        bus.blk_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_stall_valid", bus.blk_valid, 1);
            check("t2_stall_addr", bus.blk_addr, 9);
            check("t2_stall_last", bus.blk_last, 0);
            tick();
        end
        bus.blk_ready = 1'b1;
        wait_end("t2");
        repeat (2) tick();

        // Single-block packet.
        start_pkt(7, c0);
        push_blk(7, 1, c0 + 3);
        push_free(7, c0 + 4);
        exp_done.push_back(c0 + 4);
        wait_end("t3");
        check("t3_blk_count", bus.blk_count, 1);
        repeat (2) tick();

        // Null head.
        start_pkt(0, c0);
        exp_err.push_back(c0 + 1);
        @(negedge clk);
        check("t4_err", bus.err, 1);
        check("t4_ctrl_raddr", bus.ctrl_raddr, 0);
        check("t4_start_ready", bus.start_ready, 1);
        repeat (3) tick();
        @(negedge clk);
        check("t4_blk_count", bus.blk_count, 1);
        tick();

        // Unallocated entry mid-chain 3 -> 4.
        start_pkt(3, c0);
        push_blk(3, 0, c0 + 3);
        push_free(3, c0 + 4);
        exp_err.push_back(c0 + 6);
        wait_end("t5");
        check("t5_blk_count", bus.blk_count, 1);
        repeat (3) tick();

        // Self-loop 6 -> 6: 63 blocks then abort.
        start_pkt(6, c0);
        for (int k = 1; k <= 63; k++) begin
            push_blk(6, 0, c0 + 3 * k);
            push_free(6, c0 + 3 * k + 1);
        end
        exp_err.push_back(c0 + 191);
        wait_end("t6");
        check("t6_blk_count", bus.blk_count, 63);
        check("t6_start_ready", bus.start_ready, 1);
        repeat (2) tick();

        // Self-loop again, reset after three blocks.
        start_pkt(6, c0);
        for (int k = 1; k <= 3; k++) begin
            push_blk(6, 0, c0 + 3 * k);
            push_free(6, c0 + 3 * k + 1);
        end
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        repeat (6) tick();

        check("left_blk", exp_blk.size(), 0);
        check("left_free", exp_free.size(), 0);
        check("left_done", exp_done.size(), 0);
        check("left_err", exp_err.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
